grid_draw_scheduler: RTL and testbench

Request queue and handshake controller directly upstream of the VGA cell renderer. Accepts cell-update requests (row, column, on/off) from the step-sequencer logic, buffers them in a FIFO, converts grid coordinates to pixel coordinates, and issues one `draw_enable` pulse per request. The next request is issued only after the renderer's `drawing` flag has risen and fallen again. The block also holds off all requests until the renderer's power-up grid paint has finished.

---
 rtl/grid_draw_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_grid_draw_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_draw_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | grid_draw_scheduler                                                      |
// | Cell-update request FIFO and draw handshake for the VGA cell renderer.   |
// | Optional build macro GRID_SCHED_COALESCE_EN merges repeated cells.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module grid_draw_scheduler #(
    parameter int DEPTH   = 16,
    parameter int X0      = 214,
    parameter int Y0      = 32,
    parameter int PITCH   = 33,
    parameter int CELLS   = 12,
    parameter int TIMEOUT = 15
) (
    input  logic                   CLOCK_50,
    input  logic                   Reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_col,
    input  logic [3:0]             req_row,
    input  logic                   req_state,
    input  logic                   drawing,
    output logic                   draw_enable,
    output logic [9:0]             X,
    output logic [8:0]             Y,
    output logic                   state,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   overflow,
    output logic                   range_err,
    output logic                   timeout_err,
    input  logic                   clr_err
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [3:0]    c_CELLS    = 4'(CELLS);
    localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);
    localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] c_BOOT      = 3'd0;
    localparam logic [2:0] c_BOOT_DONE = 3'd1;
    localparam logic [2:0] c_IDLE      = 3'd2;
    localparam logic [2:0] c_WAIT_BUSY = 3'd3;
    localparam logic [2:0] c_WAIT_DONE = 3'd4;

    logic [2:0]    r_fsm;
    logic [2:0]    w_fsm_nxt;
    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [TW-1:0] r_tmo;
    logic          r_draw_en;
    logic [9:0]    r_x;
    logic [8:0]    r_y;
    logic          r_state;
    logic          r_overflow;
    logic          r_range_err;
    logic          r_timeout_err;

    logic          w_in_range;
    logic          w_push;
    logic          w_append;
    logic          w_pop;
    logic          w_tmo_hit;
    logic          w_hit;
    logic [AW-1:0] w_hit_idx;
    logic [8:0]    w_head;
    logic [9:0]    w_pix_x;
    logic [8:0]    w_pix_y;

    assign req_ready   = (r_count != c_DEPTH);
    assign w_in_range  = (req_col < c_CELLS) && (req_row < c_CELLS);
    assign w_push      = req_valid && req_ready && w_in_range;
    assign w_append    = w_push && !w_hit;

    // Entry layout is {row[8:5], col[4:1], state[0]}
    assign w_head  = r_mem[r_rd_ptr];
    assign w_pix_x = 10'(X0) + 10'(PITCH) * {6'd0, w_head[4:1]};
    assign w_pix_y = 9'(Y0) + 9'(PITCH) * {5'd0, w_head[8:5]};

`ifdef GRID_SCHED_COALESCE_EN
    // Later offsets overwrite earlier hits, so the youngest match wins.
    always_comb begin : p_match
        logic [AW-1:0] v_idx;
        v_idx     = '0;
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_rd_ptr + AW'(k);
            if ((k < int'(r_count)) && !((k == 0) && w_pop) &&
                (r_mem[v_idx][8:1] == {req_row, req_col})) begin
                w_hit     = 1'b1;
                w_hit_idx = v_idx;
            end
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_idx = '0;
`endif

    always_comb begin
        w_fsm_nxt = r_fsm;
        w_pop     = 1'b0;
        w_tmo_hit = 1'b0;
        case (r_fsm)
            c_BOOT:      if (drawing) w_fsm_nxt = c_BOOT_DONE;
            c_BOOT_DONE: if (!drawing) w_fsm_nxt = c_IDLE;
            c_IDLE: begin
                // Holding off while drawing is high keeps the pulse clear of a busy renderer.
                if ((r_count != '0) && !drawing) begin
                    w_pop     = 1'b1;
                    w_fsm_nxt = c_WAIT_BUSY;
                end
            end
            c_WAIT_BUSY: begin
                if (drawing) begin
                    w_fsm_nxt = c_WAIT_DONE;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_tmo_hit = 1'b1;
                    w_fsm_nxt = c_IDLE;
                end
            end
            c_WAIT_DONE: if (!drawing) w_fsm_nxt = c_IDLE;
            default:     w_fsm_nxt = c_BOOT;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_fsm         <= c_BOOT;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_tmo         <= '0;
            r_draw_en     <= 1'b0;
            r_x           <= 10'(X0);
            r_y           <= 9'(Y0);
            r_state       <= 1'b0;
            r_overflow    <= 1'b0;
            r_range_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_fsm     <= w_fsm_nxt;
            r_draw_en <= w_pop;
            r_tmo     <= (r_fsm == c_WAIT_BUSY) ? r_tmo + TW'(1) : '0;
            if (w_append) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_x      <= w_pix_x;
                r_y      <= w_pix_y;
                r_state  <= w_head[0];
            end
            r_count       <= r_count + CW'(w_append) - CW'(w_pop);
            r_overflow    <= !clr_err && (r_overflow || (req_valid && !req_ready));
            r_range_err   <= !clr_err && (r_range_err || (req_valid && !w_in_range));
            r_timeout_err <= !clr_err && (r_timeout_err || w_tmo_hit);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_append) r_mem[r_wr_ptr] <= {req_row, req_col, req_state};
        if (w_push && w_hit) r_mem[w_hit_idx][0] <= req_state;
    end

    assign draw_enable = r_draw_en;
    assign X           = r_x;
    assign Y           = r_y;
    assign state       = r_state;
    assign busy        = (r_fsm != c_IDLE);
    assign pending     = r_count;
    assign overflow    = r_overflow;
    assign range_err   = r_range_err;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_grid_draw_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_grid_draw_scheduler                                                   |
// | Directed bench: coordinate table plus boot/handshake/error sequences.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_grid_draw_scheduler;
    logic       CLOCK_50 = 1'b0;
    logic       Reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_col = '0;
    logic [3:0] req_row = '0;
    logic       req_state = 1'b0;
    logic       drawing = 1'b0;
    logic       draw_enable;
    logic [9:0] X;
    logic [8:0] Y;
    logic       state;
    logic       busy;
    logic [4:0] pending;
    logic       overflow;
    logic       range_err;
    logic       timeout_err;
    logic       clr_err = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
        logic       st;
        int         ex;
        int         ey;
    } vec_t;
    vec_t tbl [6];

    grid_draw_scheduler dut (
        .CLOCK_50(CLOCK_50), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_col(req_col), .req_row(req_row), .req_state(req_state), .drawing(drawing),
        .draw_enable(draw_enable), .X(X), .Y(Y), .state(state), .busy(busy),
        .pending(pending), .overflow(overflow), .range_err(range_err),
        .timeout_err(timeout_err), .clr_err(clr_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] row, input logic [3:0] col, input logic st);
        req_row   = row;
        req_col   = col;
        req_state = st;
        req_valid = 1'b1;
        tick(1);
        req_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int bound, output int n);
        n = 0;
        while (!draw_enable && n < bound) begin
            tick(1);
            n++;
        end
        if (!draw_enable) n = -1;
    endtask

    task automatic serve(input string name, input int ex, input int ey, input int est, input int hold);
        int n;
        int viol;
        wait_pulse(40, n);
        chk({name, " pulse seen"}, int'(n >= 0), 1);
        if (n >= 0) begin
            chk({name, " X"}, int'(X), ex);
            chk({name, " Y"}, int'(Y), ey);
            chk({name, " state"}, int'(state), est);
            viol = int'(drawing);
            tick(1);
            chk({name, " pulse width"}, int'(draw_enable), 0);
            drawing = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick(1);
                if (draw_enable) viol++;
            end
            drawing = 1'b0;
            chk({name, " no pulse while drawing"}, viol, 0);
        end
    endtask

    task automatic start_stall();
        int n;
        push(4'd0, 4'd0, 1'b0);
        wait_pulse(40, n);
        chk("stall pulse", int'(n >= 0), 1);
        tick(1);
        drawing = 1'b1;
        tick(1);
    endtask

    initial begin
        int n;
        int viol;
        tbl[0] = '{4'd0,  4'd0,  1'b1, 214, 32};
        tbl[1] = '{4'd0,  4'd1,  1'b0, 247, 32};
        tbl[2] = '{4'd11, 4'd11, 1'b1, 577, 395};
        tbl[3] = '{4'd5,  4'd3,  1'b1, 313, 197};
        tbl[4] = '{4'd11, 4'd0,  1'b0, 214, 395};
        tbl[5] = '{4'd7,  4'd10, 1'b1, 544, 263};

        tick(3);
        chk("reset pending", int'(pending), 0);
        chk("reset req_ready", int'(req_ready), 1);
        chk("reset draw_enable", int'(draw_enable), 0);
        chk("reset X", int'(X), 214);
        chk("reset Y", int'(Y), 32);
        chk("reset state", int'(state), 0);
        chk("reset busy", int'(busy), 1);
        chk("reset flags", int'({overflow, range_err, timeout_err}), 0);
        Reset = 1'b0;

        // Requests queued during boot must wait for the paint rise-and-fall.
        for (int i = 0; i < 3; i++) push(tbl[i].row, tbl[i].col, tbl[i].st);
        chk("boot pending", int'(pending), 3);
        viol = 0;
        repeat (6) begin tick(1); if (draw_enable) viol++; end
        drawing = 1'b1;
        repeat (3) begin tick(1); if (draw_enable) viol++; end
        drawing = 1'b0;
        tick(1);
        if (draw_enable) viol++;
        chk("boot hold-off", viol, 0);
        for (int i = 0; i < 3; i++) serve($sformatf("boot%0d", i), tbl[i].ex, tbl[i].ey, int'(tbl[i].st), 3);

        for (int i = 3; i < 6; i++) begin
            tick(2);
            push(tbl[i].row, tbl[i].col, tbl[i].st);
            wait_pulse(40, n);
            chk($sformatf("vec%0d latency", i), n, 1);
            serve($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, int'(tbl[i].st), 3);
        end

        // Long draw, then the next pulse two edges after drawing drops.
        tick(2);
        push(4'd4, 4'd4, 1'b1);
        push(4'd6, 4'd2, 1'b0);
        serve("hs A", 346, 164, 1, 961);
        wait_pulse(40, n);
        chk("hs gap", n, 2);
        serve("hs B", 280, 230, 0, 3);

        tick(2);
        push(4'd3, 4'd12, 1'b1);
        chk("range pending", int'(pending), 0);
        chk("range_err set", int'(range_err), 1);
        req_row = 4'd12; req_col = 4'd0; req_valid = 1'b1; clr_err = 1'b1;
        tick(1);
        req_valid = 1'b0; clr_err = 1'b0;
        chk("range clr priority", int'(range_err), 0);
        chk("range no pulse", int'(draw_enable), 0);

        tick(2);
        start_stall();
        for (int i = 0; i < 16; i++) push(4'(i % 12), 4'((i + 3) % 12), 1'(i & 1));
        chk("full pending", int'(pending), 16);
        chk("full req_ready", int'(req_ready), 0);
        chk("full no overflow yet", int'(overflow), 0);
        push(4'd1, 4'd1, 1'b1);
        chk("overflow pending", int'(pending), 16);
        chk("overflow set", int'(overflow), 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("overflow cleared", int'(overflow), 0);
        drawing = 1'b0;
        for (int i = 0; i < 16; i++)
            serve($sformatf("drain%0d", i), 214 + 33 * ((i + 3) % 12), 32 + 33 * (i % 12), i & 1, 1);
        tick(2);
        chk("drain pending", int'(pending), 0);

        tick(2);
        push(4'd9, 4'd4, 1'b1);
        push(4'd10, 4'd8, 1'b0);
        wait_pulse(40, n);
        chk("tmo pulse", int'(n >= 0), 1);
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            if (k == 14) chk("tmo not early", int'(timeout_err), 0);
            if (k == 15) begin
                chk("tmo set", int'(timeout_err), 1);
                chk("tmo idle", int'(busy), 0);
            end
            if (k == 16) chk("tmo next pulse", int'(draw_enable), 1);
        end
        serve("tmo next", 478, 362, 0, 3);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("tmo cleared", int'(timeout_err), 0);

        tick(2);
        start_stall();
        push(4'd2, 4'd5, 1'b1);
        push(4'd2, 4'd5, 1'b0);
`ifdef GRID_SCHED_COALESCE_EN
        chk("coal pending", int'(pending), 1);
        drawing = 1'b0;
        serve("coal single", 379, 98, 0, 2);
`else
        chk("coal pending", int'(pending), 2);
        drawing = 1'b0;
        serve("coal first", 379, 98, 1, 2);
        serve("coal second", 379, 98, 0, 2);
`endif
        tick(4);
        chk("coal drained", int'(pending), 0);

        // Reset during a draw empties the queue and waits for a fresh rise-and-fall.
        tick(2);
        start_stall();
        push(4'd1, 4'd1, 1'b1);
        chk("mid pending", int'(pending), 1);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        chk("mid reset pending", int'(pending), 0);
        chk("mid reset busy", int'(busy), 1);
        chk("mid reset X", int'(X), 214);
        tick(2);
        drawing = 1'b0;
        viol = 0;
        repeat (6) begin tick(1); if (draw_enable) viol++; end
        chk("mid reset no pulse", viol, 0);
        chk("mid reset idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
